// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter: instruction fetch (IF) vs load/store (LS).
// LS has fixed priority, with a starvation guard that hands the port to IF
// after STARVE_LIM consecutive denied IF cycles. Granted commands are
// registered onto the memory port. A tag pipe that matches the memory read
// latency routes each returning word back to the requester that issued it.
module mem_port_arbiter #(
  parameter int          READ_LAT   = 1,
  parameter int          STARVE_LIM = 4,
  parameter logic [31:0] DATA_BASE  = 32'h0000_1000,
  parameter logic [31:0] DATA_LIMIT = 32'h0000_1FFF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  input  logic        i_if_flush,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  input  logic        i_ls_req,
  input  logic        i_ls_we,
  input  logic [31:0] i_ls_addr,
  input  logic [31:0] i_ls_wdata,
  output logic        o_ls_gnt,
  output logic        o_ls_rvalid,
  output logic [31:0] o_ls_rdata,
  output logic        o_ls_err,
  output logic        o_we,
  output logic [31:0] o_addr,
  output logic [31:0] o_wdata,
  input  logic [31:0] i_rdata
);

  localparam int DEPTH = READ_LAT + 1;
  localparam int CW    = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

  typedef struct packed {
    logic valid;
    logic owner_ls;
    logic is_store;
    logic err;
  } tag_t;

  logic [CW-1:0] r_starve_cnt;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  tag_t          r_tag [DEPTH];

  logic w_if_prio;
  logic w_ls_gnt;
  logic w_if_gnt;
  logic w_ls_legal;
  tag_t w_new_tag;
  tag_t w_head;

  // Drops an IF entry when a flush is active; LS entries pass untouched.
  function automatic tag_t f_flush(input tag_t t, input logic fl);
    tag_t r;
    r = t;
    if (fl && !t.owner_ls) r.valid = 1'b0;
    return r;
  endfunction

  assign w_ls_legal = (i_ls_addr[1:0] == 2'b00) &&
                      (i_ls_addr >= DATA_BASE) &&
                      (i_ls_addr <= DATA_LIMIT);

  // Grants are suppressed while reset is asserted so nothing is accepted
  // that the cleared pipe would then lose.
  assign w_if_prio = i_if_req && (r_starve_cnt == CW'(STARVE_LIM));
  assign w_ls_gnt  = i_rst_n && i_ls_req && !w_if_prio;
  assign w_if_gnt  = i_rst_n && i_if_req && !w_ls_gnt;

  assign o_ls_gnt = w_ls_gnt;
  assign o_if_gnt = w_if_gnt;

  // Count consecutive denied IF cycles, saturating at the priority threshold.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_starve_cnt <= '0;
    end else if (!i_if_req || w_if_gnt) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != CW'(STARVE_LIM)) begin
      r_starve_cnt <= r_starve_cnt + CW'(1);
    end
  end

  // Register the granted command onto the memory port for one cycle.
  // Rejected LS accesses leave the address untouched and never write.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_if_gnt) begin
        r_addr <= i_if_addr;
      end else if (w_ls_gnt && w_ls_legal) begin
        r_addr <= i_ls_addr;
        r_we   <= i_ls_we;
        if (i_ls_we) r_wdata <= i_ls_wdata;
      end
    end
  end

  assign o_we    = r_we;
  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;

  // Build the tag for this cycle's grant; a flushed IF grant gets no tag.
  always_comb begin
    w_new_tag = '0;
    if (w_ls_gnt) begin
      w_new_tag.valid    = 1'b1;
      w_new_tag.owner_ls = 1'b1;
      w_new_tag.is_store = i_ls_we;
      w_new_tag.err      = !w_ls_legal;
    end else if (w_if_gnt && !i_if_flush) begin
      w_new_tag.valid    = 1'b1;
    end
  end

  // Shift tags in step with the memory latency, killing IF entries on flush.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= w_new_tag;
      for (int i = 1; i < DEPTH; i++) r_tag[i] <= f_flush(r_tag[i-1], i_if_flush);
    end
  end

  // The oldest tag lines up with i_rdata. A flush in the cycle an IF word
  // returns also suppresses it, so no pre-flush fetch ever reaches IF.
  assign w_head      = r_tag[READ_LAT];
  assign o_if_rvalid = w_head.valid && !w_head.owner_ls && !i_if_flush;
  assign o_if_rdata  = o_if_rvalid ? i_rdata : '0;
  assign o_ls_rvalid = w_head.valid && w_head.owner_ls;
  assign o_ls_err    = o_ls_rvalid && w_head.err;
  assign o_ls_rdata  = (o_ls_rvalid && !w_head.is_store && !w_head.err) ? i_rdata : '0;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the core's single shared memory port between instruction fetch (IF) and load/store (LS) requesters.
- Drives the same o_we/o_addr/o_wdata/i_rdata interface that the core presents to data_mem, with one access per cycle.
- Handles fixed LS priority with an IF starvation guard, in-flight response tagging, fetch flush, and LS address checking.

Parameters:
- READ_LAT, 1, memory cycles from command presented on o_addr to valid i_rdata (legal range 0..3).
- STARVE_LIM, 4, consecutive denied IF-request cycles after which IF gets priority.
- DATA_BASE, 32'h0000_1000, lowest legal LS byte address.
- DATA_LIMIT, 32'h0000_1FFF, highest legal LS byte address.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_if_req  in  1  fetch request.
- i_if_addr  in  32  fetch byte address.
- i_if_flush  in  1  discard all in-flight fetch responses.
- o_if_gnt  out  1  fetch accepted this cycle.
- o_if_rvalid  out  1  fetch data valid.
- o_if_rdata  out  32  fetch data.
- i_ls_req  in  1  load/store request.
- i_ls_we  in  1  1 = store.
- i_ls_addr  in  32  LS byte address.
- i_ls_wdata  in  32  store data.
- o_ls_gnt  out  1  LS accepted this cycle.
- o_ls_rvalid  out  1  LS response: load data valid, or store done.
- o_ls_rdata  out  32  load data.
- o_ls_err  out  1  qualifies o_ls_rvalid: access rejected.
- o_we  out  1  memory write enable.
- o_addr  out  32  memory byte address.
- o_wdata  out  32  memory write data.
- i_rdata  in  32  memory read data.

Behaviour:
- Reset: at a posedge with i_rst_n=0, all registers clear. Reset values: o_we=0, o_addr=0, o_wdata=0, all rvalid and err outputs 0, starvation counter 0, tag pipe empty. Reset wins over any concurrent request; responses in flight are dropped.
- Grant (combinational, cycle N): LS wins by default. If starve_cnt==STARVE_LIM and i_if_req=1, IF wins. At most one grant per cycle. A requester must hold req/addr/wdata until it sees its gnt.
- starve_cnt: increments (saturating at STARVE_LIM) on cycles with i_if_req=1 and o_if_gnt=0. Clears on an IF grant or when i_if_req=0.
- Command register: the granted command appears on o_addr/o_we/o_wdata in cycle N+1 and is held for exactly one cycle. With no grant, o_we=0 and o_addr holds its value.
- o_we=1 only for a granted, legal LS store.
- LS check:
  - Illegal if i_ls_addr[1:0]!=0, i_ls_addr<DATA_BASE, or i_ls_addr>DATA_LIMIT.
  - An illegal request is still granted, but o_we=0 and the address is not driven to memory.
  - Its response carries o_ls_err=1 and o_ls_rdata=0, with the same timing as a legal access.
- IF addresses are not checked.
- Tag pipe: depth 1+READ_LAT. Each entry holds {valid, owner, is_store, err}.
- Response: in cycle N+1+READ_LAT:
  - owner IF: o_if_rvalid=1, o_if_rdata=i_rdata.
  - owner LS: o_ls_rvalid=1, o_ls_rdata=i_rdata for loads, 0 for stores or errors.
- Responses return strictly in grant order. Each rvalid is a one-cycle pulse.
- Flush: i_if_flush=1 in cycle M clears the valid bit of every IF entry in the pipe, so no o_if_rvalid comes from grants made before M. An IF grant in cycle M itself is also suppressed. LS entries are unaffected.
- Back-to-back grants every cycle are legal; no bubbles are inserted.
- Store followed by a load to the same address in the next cycle: the load sees the stored data, because memory sees the write one cycle earlier.

Test Plan:
- Reset with i_if_req=1, i_ls_req=1 held -> no gnt, o_we=0, o_addr=0, no rvalid while reset; after release, LS granted first.
- Word 1024 preloaded with 32'hDEADBEEF; LS load to 0x1000 (READ_LAT=1) granted cycle N -> o_addr=0x1000 in N+1; o_ls_rvalid=1 with o_ls_rdata=32'hDEADBEEF in N+2.
- IF and LS both requesting continuously, STARVE_LIM=4 -> LS granted 4 cycles, IF granted on the 5th, counter clears, pattern repeats; IF never waits more than 5 cycles.
- LS store to 0x1002, then 0x0FFC, then 0x2000 -> all granted, o_we stays 0, three o_ls_rvalid pulses with o_ls_err=1; memory unchanged.
- IF grants in cycles N and N+1, i_if_flush in N+1 -> no o_if_rvalid for either; an IF grant in N+2 returns normally in N+4.
- Store 32'h1234_5678 to 0x1FFC in cycle N, load 0x1FFC in N+1 -> load responds with 32'h1234_5678; memory word 2047 matches at end of simulation.
